// File: rtl/isbm_pkg.sv
// rtl/isbm_pkg.sv - shared flit-type and state encodings for the input buffer manager
package isbm_pkg;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        HEAD = 2'b01,
        DATA = 2'b10,
        TAIL = 2'b11
    } flit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        AREQ  = 2'b01,
        XFER  = 2'b10,
        DRAIN = 2'b11
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - first set request bit at or after a start pointer, with wrap
module rr_pick #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] mask,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    // walk the ring starting at ptr, keep the first hit
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            int j;
            j = (int'(ptr) + i) % N;
            if (!found && mask[j]) begin
                found = 1'b1;
                idx   = j[W-1:0];
            end
        end
    end

endmodule

// File: rtl/isbm_vc.sv
// rtl/isbm_vc.sv - multi-VC input buffer manager: round-robin VC pick, request, packet stream
module isbm_vc
    import isbm_pkg::*;
#(
    parameter int NVC    = 4,
    parameter int NPORT  = 5,
    parameter int MAXLEN = 16,
    parameter int VCW    = (NVC > 1) ? $clog2(NVC) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2*NVC-1:0]     pout,
    input  logic [NVC-1:0]       empty,
    input  logic [NVC*NPORT-1:0] reqi,
    output logic [NVC-1:0]       re,
    output logic [NPORT-1:0]     req,
    input  logic                 ack,
    output logic [VCW-1:0]       sel,
    output logic                 vld,
    output logic                 err,
    output logic                 busy
);

    localparam int CW = $clog2(MAXLEN + 1);

    state_t           state, nstate;
    logic [VCW-1:0]   rr_ptr, rr_nxt;
    logic [VCW-1:0]   vc, vc_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;

    logic             pick_found;
    logic [VCW-1:0]   pick_idx;
    flit_t            pick_ft;
    flit_t            cur_ft;
    logic             cur_empty;
    logic [NPORT-1:0] cur_req;
    logic             last_legal;

    function automatic logic [VCW-1:0] next_vc(input logic [VCW-1:0] v);
        return (v == VCW'(NVC - 1)) ? '0 : v + VCW'(1);
    endfunction

    rr_pick #(.N(NVC), .W(VCW)) u_pick (
        .mask  (~empty),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign pick_ft    = flit_t'(pout[2*pick_idx +: 2]);
    assign cur_ft     = flit_t'(pout[2*vc +: 2]);
    assign cur_empty  = empty[vc];
    assign cur_req    = reqi[vc*NPORT +: NPORT];
    // a non-TAIL pop at this count makes the packet one flit too long
    assign last_legal = (cnt == CW'(MAXLEN - 1));

    // state and bookkeeping registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            vc     <= '0;
            cnt    <= '0;
        end else begin
            state  <= nstate;
            rr_ptr <= rr_nxt;
            vc     <= vc_nxt;
            cnt    <= cnt_nxt;
        end
    end

    // next state, pointer, latched VC and flit count
    always_comb begin
        nstate  = state;
        rr_nxt  = rr_ptr;
        vc_nxt  = vc;
        cnt_nxt = cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    if (pick_ft == HEAD) begin
                        vc_nxt = pick_idx;
                        nstate = AREQ;
                    end else begin
                        rr_nxt = next_vc(pick_idx);
                    end
                end
            end
            AREQ: begin
                if (ack) begin
                    cnt_nxt = CW'(1);
                    nstate  = XFER;
                end
            end
            XFER: begin
                if (!cur_empty) begin
                    case (cur_ft)
                        TAIL, HEAD: begin
                            nstate  = IDLE;
                            rr_nxt  = next_vc(vc);
                            cnt_nxt = '0;
                        end
                        default: begin
                            if (last_legal) begin
                                nstate  = DRAIN;
                                cnt_nxt = '0;
                            end else begin
                                cnt_nxt = cnt + CW'(1);
                            end
                        end
                    endcase
                end
            end
            DRAIN: begin
                if (!cur_empty && (cur_ft == TAIL || cur_ft == HEAD)) begin
                    nstate = IDLE;
                    rr_nxt = next_vc(vc);
                end
            end
            default: nstate = IDLE;
        endcase
    end

    // combinational outputs; everything quiet while reset is asserted
    always_comb begin
        re   = '0;
        req  = '0;
        sel  = '0;
        vld  = 1'b0;
        err  = 1'b0;
        busy = 1'b0;
        if (rst) begin
            busy = (state != IDLE);
            case (state)
                IDLE: begin
                    if (pick_found && pick_ft != HEAD) begin
                        re[pick_idx] = 1'b1;
                        err          = 1'b1;
                    end
                end
                AREQ: begin
                    req = cur_req;
                    sel = vc;
                    if (ack) begin
                        re[vc] = 1'b1;
                        vld    = 1'b1;
                    end
                end
                XFER: begin
                    req = cur_req;
                    sel = vc;
                    if (!cur_empty) begin
                        if (cur_ft == HEAD) begin
                            err = 1'b1;
                        end else begin
                            re[vc] = 1'b1;
                            vld    = 1'b1;
                            err    = (cur_ft != TAIL) && last_legal;
                        end
                    end
                end
                DRAIN: begin
                    sel = vc;
                    if (!cur_empty && cur_ft != HEAD) begin
                        re[vc] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_isbm_vc.sv
// tb/tb_isbm_vc.sv - self-checking bench for isbm_vc
module tb_isbm_vc;

    localparam int NVC    = 4;
    localparam int NPORT  = 5;
    localparam int MAXLEN = 4;
    localparam int VCW    = 2;

    localparam logic [1:0] FH = 2'b01;
    localparam logic [1:0] FD = 2'b10;
    localparam logic [1:0] FT = 2'b11;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [2*NVC-1:0]     pout;
    logic [NVC-1:0]       empty;
    logic [NVC*NPORT-1:0] reqi;
    logic [NVC-1:0]       re;
    logic [NPORT-1:0]     req;
    logic                 ack;
    logic [VCW-1:0]       sel;
    logic                 vld;
    logic                 err;
    logic                 busy;

    isbm_vc #(.NVC(NVC), .NPORT(NPORT), .MAXLEN(MAXLEN)) dut (
        .clk   (clk),
        .rst   (rst),
        .pout  (pout),
        .empty (empty),
        .reqi  (reqi),
        .re    (re),
        .req   (req),
        .ack   (ack),
        .sel   (sel),
        .vld   (vld),
        .err   (err),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [1:0]       q [NVC][$];
    logic [NPORT-1:0] dst [NVC];
    logic [NVC-1:0]   umask;
    logic             model_en;

    logic [NVC-1:0]   o_re;
    logic [NPORT-1:0] o_req;
    logic [VCW-1:0]   o_sel;
    logic             o_vld, o_err, o_busy;

    typedef struct {
        logic [NVC-1:0]   empty;
        logic [2*NVC-1:0] pout;
        logic [NVC-1:0]   exp_re;
        logic             exp_err;
        logic             exp_busy;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int v = 0; v < NVC; v++) begin
            empty[v]            = (q[v].size() == 0) || umask[v];
            pout[2*v +: 2]      = (q[v].size() != 0) ? q[v][0] : 2'b00;
            reqi[v*NPORT +: NPORT] = dst[v];
        end
    endtask

    // one cycle: drive inputs, sample outputs mid-cycle, pop on the edge
    task automatic step();
        if (model_en) drive();
        #1;
        o_re = re; o_req = req; o_sel = sel; o_vld = vld; o_err = err; o_busy = busy;
        @(posedge clk);
        if (model_en)
            for (int v = 0; v < NVC; v++)
                if (o_re[v] && q[v].size() != 0) void'(q[v].pop_front());
        @(negedge clk);
    endtask

    task automatic push_pkt(input int v, input int ndata);
        q[v].push_back(FH);
        for (int i = 0; i < ndata; i++) q[v].push_back(FD);
        q[v].push_back(FT);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; ack = 1'b0; umask = '0; model_en = 1'b1;
        pout = '0; empty = '1; reqi = '0;
        dst[0] = 5'b00001; dst[1] = 5'b00100; dst[2] = 5'b01000; dst[3] = 5'b10000;
        @(negedge clk);

        // reset holds outputs low even with a HEAD waiting
        push_pkt(1, 0);
        step();
        chk("rst_re", o_re, 0); chk("rst_req", o_req, 0); chk("rst_busy", o_busy, 0);
        chk("rst_err", o_err, 0); chk("rst_vld", o_vld, 0);
        q[1].delete();

        // IDLE selection table, pointer fresh from reset
        vt[0] = '{4'b1111, 8'b00_00_00_00, 4'b0000, 1'b0, 1'b0};
        vt[1] = '{4'b1110, 8'b00_00_00_10, 4'b0001, 1'b1, 1'b0};
        vt[2] = '{4'b1101, 8'b00_00_01_00, 4'b0000, 1'b0, 1'b1};
        vt[3] = '{4'b1011, 8'b00_00_00_00, 4'b0100, 1'b1, 1'b0};
        vt[4] = '{4'b0110, 8'b11_00_00_01, 4'b0000, 1'b0, 1'b1};
        vt[5] = '{4'b1100, 8'b00_00_01_11, 4'b0001, 1'b1, 1'b0};
        vt[6] = '{4'b0111, 8'b10_01_01_01, 4'b1000, 1'b1, 1'b0};
        model_en = 1'b0;
        reqi = '0;
        for (int i = 0; i < 7; i++) begin
            do_reset();
            empty = vt[i].empty;
            pout  = vt[i].pout;
            step();
            chk($sformatf("tab%0d_re", i), o_re, vt[i].exp_re);
            chk($sformatf("tab%0d_err", i), o_err, vt[i].exp_err);
            chk($sformatf("tab%0d_vld", i), o_vld, 0);
            step();
            chk($sformatf("tab%0d_busy", i), o_busy, vt[i].exp_busy);
        end
        model_en = 1'b1;

        // single packet on VC1, ack two cycles after the request
        do_reset();
        push_pkt(1, 2);
        for (int c = 0; c < 8; c++) begin
            ack = (c == 3);
            step();
            chk($sformatf("t1_req c%0d", c), o_req, (c >= 1 && c <= 6) ? 32'h4 : 32'h0);
            chk($sformatf("t1_re c%0d", c), o_re, (c >= 3 && c <= 6) ? 32'h2 : 32'h0);
            chk($sformatf("t1_vld c%0d", c), o_vld, (c >= 3 && c <= 6) ? 32'h1 : 32'h0);
            chk($sformatf("t1_busy c%0d", c), o_busy, (c >= 1 && c <= 6) ? 32'h1 : 32'h0);
            if (c >= 1 && c <= 6) chk($sformatf("t1_sel c%0d", c), o_sel, 1);
        end
        chk("t1_drained", q[1].size(), 0);

        // fairness between VC0 and VC2, immediate ack
        begin
            int grants [$];
            logic [NPORT-1:0] prev;
            do_reset();
            push_pkt(0, 0); push_pkt(0, 0); push_pkt(2, 0);
            ack = 1'b1;
            prev = '0;
            for (int c = 0; c < 10; c++) begin
                step();
                if (prev == 0 && o_req != 0) begin
                    if (grants.size() == 2) chk("fair_ptr", dut.rr_ptr, 3);
                    chk($sformatf("fair_req%0d", grants.size()), o_req, dst[o_sel]);
                    grants.push_back(int'(o_sel));
                end
                prev = o_req;
            end
            chk("fair_n", grants.size(), 3);
            if (grants.size() == 3) begin
                chk("fair_g0", grants[0], 0);
                chk("fair_g1", grants[1], 2);
                chk("fair_g2", grants[2], 0);
            end
            chk("fair_busy", o_busy, 0);
        end

        // underrun: VC1 looks empty for three cycles mid-packet
        do_reset();
        push_pkt(1, 2);
        ack = 1'b1;
        for (int c = 0; c < 9; c++) begin
            umask[1] = (c >= 2 && c <= 4);
            step();
            chk($sformatf("ur_re c%0d", c), o_re,
                (c == 1 || (c >= 5 && c <= 7)) ? 32'h2 : 32'h0);
            chk($sformatf("ur_vld c%0d", c), o_vld,
                (c == 1 || (c >= 5 && c <= 7)) ? 32'h1 : 32'h0);
            chk($sformatf("ur_req c%0d", c), o_req, (c >= 1 && c <= 7) ? 32'h4 : 32'h0);
            chk($sformatf("ur_err c%0d", c), o_err, 0);
        end
        umask = '0;
        chk("ur_drained", q[1].size(), 0);

        // overlong packet on VC2 with MAXLEN=4
        begin
            int nv;
            do_reset();
            push_pkt(2, 5);
            nv = 0;
            for (int c = 0; c < 9; c++) begin
                step();
                if (o_vld) nv++;
                chk($sformatf("ol_err c%0d", c), o_err, (c == 4) ? 32'h1 : 32'h0);
                chk($sformatf("ol_re c%0d", c), o_re, (c >= 1 && c <= 7) ? 32'h4 : 32'h0);
                chk($sformatf("ol_req c%0d", c), o_req, (c >= 1 && c <= 4) ? 32'h8 : 32'h0);
                chk($sformatf("ol_busy c%0d", c), o_busy, (c >= 1 && c <= 7) ? 32'h1 : 32'h0);
            end
            chk("ol_nvld", nv, 4);
            chk("ol_drained", q[2].size(), 0);
        end

        // missing TAIL: a new HEAD shows up mid-XFER on VC0
        do_reset();
        q[0].push_back(FH); q[0].push_back(FD);
        push_pkt(0, 0);
        for (int c = 0; c < 8; c++) begin
            step();
            chk($sformatf("mt_err c%0d", c), o_err, (c == 3) ? 32'h1 : 32'h0);
            chk($sformatf("mt_re c%0d", c), o_re,
                (c == 1 || c == 2 || c == 5 || c == 6) ? 32'h1 : 32'h0);
            chk($sformatf("mt_req c%0d", c), o_req,
                ((c >= 1 && c <= 3) || c == 5 || c == 6) ? 32'h1 : 32'h0);
        end
        chk("mt_drained", q[0].size(), 0);

        // reset during XFER on VC3, then rescan from VC0
        push_pkt(3, 2);
        for (int c = 0; c < 3; c++) step();
        chk("rx_in_xfer", o_re, 4'b1000);
        push_pkt(0, 0);
        rst = 1'b0;
        step();
        chk("rx_rst_re", o_re, 0); chk("rx_rst_req", o_req, 0);
        rst = 1'b1;
        step();
        chk("rx_re", o_re, 0); chk("rx_req", o_req, 0); chk("rx_err", o_err, 0);
        chk("rx_busy", o_busy, 0); chk("rx_ptr", dut.rr_ptr, 0);
        step();
        chk("rx_sel", o_sel, 0); chk("rx_req2", o_req, dst[0]); chk("rx_re2", o_re, 4'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
